// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID->EX operand register with forwarding and load-use hazard detection
//
// Purpose: latches decoded operands/control into the EX slot, supplies the ALU
// with forwarded A/B operands, and stalls decode (inserting a bubble) on a
// load-use hazard.
//
// Optional feature macro: IDEX_FORWARDING_EN
//   defined     : MEM/WB forwarding muxes on both operands (MEM wins over WB).
//   not defined : no forwarding; any in-flight EX writer or MEM writer that a
//                 decoded instruction reads causes a bubble instead.
//
// Ports:
//   clk, reset                          clock, async active-high reset
//   id_valid, id_rs, id_rt, id_uses_rt  decode slot and its source registers
//   id_rs_val, id_rt_val                register-file values for rs/rt
//   id_imm16, id_alusrc, id_sext        immediate and B-operand selection
//   id_af, id_i                         ALU function code / imm-upper flag
//   id_rd, id_regwrite, id_is_load      destination control
//   ex_stall, flush                     hold / squash the EX slot
//   mem_wr_*                            EX/MEM-stage writer (non-load)
//   wb_wr_*                             MEM/WB-stage writer
//   id_stall                            combinational decode hold
//   ex_valid, alu_a, alu_b, alu_af, alu_i, ex_rd, ex_regwrite, ex_is_load
//                                       EX slot outputs to the ALU / later stages

module id_ex_operand_stage #(
  parameter int N  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [N-1:0]  id_rs_val,
  input  logic [N-1:0]  id_rt_val,
  input  logic [15:0]   id_imm16,
  input  logic          id_alusrc,
  input  logic          id_sext,
  input  logic [3:0]    id_af,
  input  logic          id_i,
  input  logic [RA-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_is_load,
  input  logic          ex_stall,
  input  logic          flush,
  input  logic          mem_wr_en,
  input  logic [RA-1:0] mem_wr_addr,
  input  logic [N-1:0]  mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [RA-1:0] wb_wr_addr,
  input  logic [N-1:0]  wb_wr_data,
  output logic          id_stall,
  output logic          ex_valid,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_af,
  output logic          alu_i,
  output logic [RA-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_is_load
);

  logic          ex_valid_q;
  logic [RA-1:0] rs_q, rt_q, rd_q;
  logic [N-1:0]  rs_val_q, rt_val_q;
  logic [15:0]   imm_q;
  logic          alusrc_q, sext_q, i_q, regwrite_q, is_load_q;
  logic [3:0]    af_q;

  logic [N-1:0]  fwd_rs, fwd_rt, imm_ext;
  logic          hz_load, hz;

  // Does the decoded instruction read register r? Register 0 never counts.
  function automatic logic id_reads(input logic [RA-1:0] r, input logic [RA-1:0] rs,
                                    input logic [RA-1:0] rt, input logic uses_rt);
    return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign hz_load = ex_valid_q & is_load_q & id_valid & id_reads(rd_q, id_rs, id_rt, id_uses_rt);

`ifdef IDEX_FORWARDING_EN
  // MEM is younger than WB, so it takes precedence on the same address.
  always_comb begin
    fwd_rs = rs_val_q;
    if (rs_q != '0) begin
      if (mem_wr_en && (mem_wr_addr == rs_q))      fwd_rs = mem_wr_data;
      else if (wb_wr_en && (wb_wr_addr == rs_q))   fwd_rs = wb_wr_data;
    end
  end

  always_comb begin
    fwd_rt = rt_val_q;
    if (rt_q != '0) begin
      if (mem_wr_en && (mem_wr_addr == rt_q))      fwd_rt = mem_wr_data;
      else if (wb_wr_en && (wb_wr_addr == rt_q))   fwd_rt = wb_wr_data;
    end
  end

  assign hz = hz_load;
`else
  // Without forwarding, the decoded instruction must wait until every pending
  // producer has reached WB, where the write-through register file covers it.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{wb_wr_en, wb_wr_addr, wb_wr_data, mem_wr_data};

  assign fwd_rs = rs_val_q;
  assign fwd_rt = rt_val_q;
  assign hz = hz_load
            | (id_valid & ex_valid_q & regwrite_q & id_reads(rd_q, id_rs, id_rt, id_uses_rt))
            | (id_valid & mem_wr_en & id_reads(mem_wr_addr, id_rs, id_rt, id_uses_rt));
`endif

  assign imm_ext = id_ext(imm_q, sext_q);

  function automatic logic [N-1:0] id_ext(input logic [15:0] imm, input logic sext);
    return sext ? {{(N-16){imm[15]}}, imm} : {{(N-16){1'b0}}, imm};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      sext_q     <= 1'b0;
      af_q       <= '0;
      i_q        <= 1'b0;
      regwrite_q <= 1'b0;
      is_load_q  <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (ex_stall) begin
      // Capture forwarded values so a WB result retiring during the stall
      // is not lost once it leaves the pipeline.
      rs_val_q <= fwd_rs;
      rt_val_q <= fwd_rt;
    end else if (hz) begin
      ex_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= id_valid;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
      rs_val_q   <= id_rs_val;
      rt_val_q   <= id_rt_val;
      imm_q      <= id_imm16;
      alusrc_q   <= id_alusrc;
      sext_q     <= id_sext;
      af_q       <= id_af;
      i_q        <= id_i;
      regwrite_q <= id_regwrite;
      is_load_q  <= id_is_load;
    end
  end

  assign id_stall    = hz | ex_stall;
  assign ex_valid    = ex_valid_q;
  assign alu_a       = fwd_rs;
  assign alu_b       = alusrc_q ? imm_ext : fwd_rt;
  assign alu_af      = af_q;
  assign alu_i       = i_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q & ex_valid_q;
  assign ex_is_load  = is_load_q & ex_valid_q;

endmodule
